// File: rtl/sparse_coo_encoder.sv
// sparse_coo_encoder: dense FP8 row stream to (row, col, data) COO entry stream.
//   clk, rst       : rising-edge clock, asynchronous active-low reset
//   in_valid/ready : one dense row per handshake; in_data element c at [c*DATA_W +: DATA_W]
//   in_last        : row closes the matrix
//   out_valid/ready: one COO entry per handshake (out_row, out_col, out_data)
//   done           : one-cycle pulse when a matrix is fully encoded; nnz_count valid with it
//   overflow       : sticky; nonzeros were dropped because the entry list was full
module sparse_coo_encoder #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 8,
  parameter int unsigned MAX_NNZ = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [COLS*DATA_W-1:0]         in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [$clog2(ROWS)-1:0]        out_row,
  output logic [$clog2(COLS)-1:0]        out_col,
  output logic                           done,
  output logic [$clog2(MAX_NNZ+1)-1:0]   nnz_count,
  output logic                           overflow
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned NNZ_W = $clog2(MAX_NNZ + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                   r_state;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_out_data;
  logic [COL_W-1:0]         r_out_col;
  logic [ROW_W-1:0]         r_row;
  logic                     r_done;
  logic [NNZ_W-1:0]         r_nnz;
  logic                     r_overflow;
  logic [COLS*DATA_W-1:0]   r_data;
  logic                     r_last;
  logic [COLS-1:0]          r_mask;

  logic [COLS-1:0]          w_in_mask;
  logic [COLS-1:0]          w_mask_clr;
  logic [COLS-1:0]          w_scan_mask;
  logic [NNZ_W-1:0]         w_scan_nnz;
  logic [NNZ_W-1:0]         w_nnz_base;
  logic                     w_drop;
  logic                     w_take;
  logic                     w_row_end;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [COL_W-1:0] lowest_idx(input logic [COLS-1:0] m);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (m[c]) idx = COL_W'(c);
    end
    return idx;
  endfunction

  // Element idx of a dense row.
  function automatic logic [DATA_W-1:0] elem_at(input logic [COLS*DATA_W-1:0] row,
                                                input logic [COL_W-1:0]       idx);
    logic [DATA_W-1:0] e;
    e = '0;
    for (int c = 0; c < COLS; c++) begin
      if (COL_W'(c) == idx) e = row[c*DATA_W +: DATA_W];
    end
    return e;
  endfunction

  // Next-value helpers for the mask/count registers.
  always_comb begin
    w_in_mask  = '0;
    w_mask_clr = '0;
    // Sign bit is ignored: +0 and -0 are both zero.
    for (int c = 0; c < COLS; c++) begin
      w_in_mask[c]  = |in_data[c*DATA_W +: DATA_W-1];
      w_mask_clr[c] = r_mask[c] && (COL_W'(c) != r_out_col);
    end
    w_nnz_base  = (r_row == '0) ? '0 : r_nnz;
    w_drop      = (r_state == S_SCAN) && (r_nnz == NNZ_W'(MAX_NNZ)) && (|r_mask);
    // r_out_valid is only ever set in SCAN and r_out_col is the mask's lowest bit.
    w_take      = r_out_valid && out_ready;
    w_scan_mask = w_drop ? '0 : (w_take ? w_mask_clr : r_mask);
    w_scan_nnz  = r_nnz + NNZ_W'(w_take);
    w_row_end   = r_last || (r_row == ROW_W'(ROWS - 1));
  end

  // Control FSM; every output is loaded with the value it must show next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_col   <= '0;
      r_row       <= '0;
      r_done      <= 1'b0;
      r_nnz       <= '0;
      r_overflow  <= 1'b0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_mask      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state     <= S_SCAN;
            r_in_ready  <= 1'b0;
            r_data      <= in_data;
            r_last      <= in_last;
            r_mask      <= w_in_mask;
            r_nnz       <= w_nnz_base;
            if (r_row == '0) r_overflow <= 1'b0;
            r_out_valid <= (|w_in_mask) && (w_nnz_base < NNZ_W'(MAX_NNZ));
            r_out_col   <= lowest_idx(w_in_mask);
            r_out_data  <= elem_at(in_data, lowest_idx(w_in_mask));
          end
        end
        S_SCAN: begin
          r_mask <= w_scan_mask;
          r_nnz  <= w_scan_nnz;
          if (w_drop) r_overflow <= 1'b1;
          if (w_scan_mask == '0) begin
            r_out_valid <= 1'b0;
            if (w_row_end) begin
              r_state <= S_DONE;
              r_row   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_IDLE;
              r_row      <= r_row + ROW_W'(1);
              r_in_ready <= 1'b1;
            end
          end else begin
            // List full with bits left: hold off, the next cycle drops them.
            r_out_valid <= (w_scan_nnz < NNZ_W'(MAX_NNZ));
            r_out_col   <= lowest_idx(w_scan_mask);
            r_out_data  <= elem_at(r_data, lowest_idx(w_scan_mask));
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_row   = r_row;
  assign out_col   = r_out_col;
  assign done      = r_done;
  assign nnz_count = r_nnz;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_sparse_coo_encoder.sv
// Bench for sparse_coo_encoder: a row model pushes expected entries and done
// records into queues; a negedge monitor pops and compares them as the DUT emits.
module tb_sparse_coo_encoder;

  localparam int DATA_W  = 8;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int MAX_NNZ = 8;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] data;
  } entry_t;

  typedef struct packed {
    logic [3:0] nnz;
    logic       ovf;
  } done_t;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [COLS*DATA_W-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [2:0]             out_row;
  logic [2:0]             out_col;
  logic                   done;
  logic [3:0]             nnz_count;
  logic                   overflow;

  sparse_coo_encoder #(
    .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .MAX_NNZ(MAX_NNZ)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col),
    .done(done), .nnz_count(nnz_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t exp_q[$];
  done_t  done_q[$];
  entry_t mon_e;
  done_t  mon_d;
  int     n_checks = 0;
  int     n_pass = 0;
  int     n_pop = 0;
  int     n_done = 0;
  int     n_valid_cyc = 0;
  int     cyc = 0;
  int     acc_cyc = 0;
  int     m_row = 0;
  int     m_nnz = 0;
  logic   m_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: handshakes and done pulses seen at negedge complete on the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) n_valid_cyc++;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL entry_unexpected: got row=%0d col=%0d data=%02h, expected no entry",
                   out_row, out_col, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          n_pop++;
          if ({out_row, out_col, out_data} !== mon_e)
            $display("FAIL entry: got row=%0d col=%0d data=%02h, expected row=%0d col=%0d data=%02h",
                     out_row, out_col, out_data, mon_e.row, mon_e.col, mon_e.data);
          else n_pass++;
        end
      end
      if (done) begin
        n_done++;
        n_checks++;
        if (done_q.size() == 0) begin
          $display("FAIL done_unexpected: got done nnz=%0d ovf=%0b, expected no done", nnz_count, overflow);
        end else begin
          mon_d = done_q.pop_front();
          if ({nnz_count, overflow} !== mon_d)
            $display("FAIL done_result: got nnz=%0d ovf=%0b, expected nnz=%0d ovf=%0b",
                     nnz_count, overflow, mon_d.nnz, mon_d.ovf);
          else n_pass++;
        end
      end
    end
  end

  // Reference model of one accepted row.
  task automatic model_row(input logic [COLS*DATA_W-1:0] data, input logic last);
    logic [7:0] el;
    entry_t     e;
    done_t      d;
    if (m_row == 0) begin
      m_nnz = 0;
      m_ovf = 1'b0;
    end
    for (int c = 0; c < COLS; c++) begin
      el = data[c*8 +: 8];
      if (el[6:0] != 7'd0) begin
        if (m_nnz < MAX_NNZ) begin
          e.row = 3'(m_row);
          e.col = 3'(c);
          e.data = el;
          exp_q.push_back(e);
          m_nnz++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (last || m_row == ROWS - 1) begin
      d.nnz = 4'(m_nnz);
      d.ovf = m_ovf;
      done_q.push_back(d);
      m_row = 0;
    end else begin
      m_row++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_row(input logic [COLS*DATA_W-1:0] data, input logic last);
    bit ok;
    ok = 1'b0;
    model_row(data, last);
    in_data  = data;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end else begin
      n_checks++;
      $display("FAIL accept_timeout: got in_ready=0 for 300 cycles, expected row accepted");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && done_q.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok)
      $display("FAIL %s_drain: got %0d entries and %0d dones pending, expected 0 and 0",
               name, exp_q.size(), done_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #22;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (nnz_count !== 4'd0) $display("FAIL reset_nnz: got %0d expected 0", nnz_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
  endtask

  task automatic test_identity();
    int p0, d0;
    logic [COLS*DATA_W-1:0] data;
    p0 = n_pop;
    d0 = n_done;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      data = '0;
      data[r*8 +: 8] = 8'h38;
      send_row(data, r == ROWS - 1);
    end
    wait_drain("identity");
    n_checks++; if (n_pop - p0 !== 8) $display("FAIL identity_count: got %0d entries expected 8", n_pop - p0); else n_pass++;
    n_checks++; if (n_done - d0 !== 1) $display("FAIL identity_done: got %0d pulses expected 1", n_done - d0); else n_pass++;
  endtask

  task automatic test_zero_encoding();
    logic [7:0] b [8];
    logic [COLS*DATA_W-1:0] data;
    int p0;
    b = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB8};
    for (int c = 0; c < COLS; c++) data[c*8 +: 8] = b[c];
    p0 = n_pop;
    @(posedge clk); #1;
    send_row(data, 1'b1);
    wait_drain("zero_enc");
    n_checks++; if (n_pop - p0 !== 2) $display("FAIL zero_enc_count: got %0d entries expected 2", n_pop - p0); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [COLS*DATA_W-1:0] data;
    int p0;
    data = '0;
    data[2*8 +: 8] = 8'h11;
    data[5*8 +: 8] = 8'h22;
    p0 = n_pop;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_row(data, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_row, out_col, out_data} !== {1'b1, 3'd0, 3'd2, 8'h11})
        $display("FAIL stall_hold%0d: got v=%b row=%0d col=%0d data=%02h, expected v=1 row=0 col=2 data=11",
                 i, out_valid, out_row, out_col, out_data);
      else n_pass++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("backpressure");
    n_checks++; if (n_pop - p0 !== 2) $display("FAIL backpressure_count: got %0d entries expected 2", n_pop - p0); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [COLS*DATA_W-1:0] data;
    int p0;
    data = {8{8'h40}};
    p0 = n_pop;
    @(posedge clk); #1;
    send_row(data, 1'b0);
    send_row(data, 1'b1);
    wait_drain("overflow");
    n_checks++; if (n_pop - p0 !== 8) $display("FAIL overflow_count: got %0d entries expected 8", n_pop - p0); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b expected 1", overflow); else n_pass++;
    data = '0;
    data[3*8 +: 8] = 8'h3C;
    @(posedge clk); #1;
    send_row(data, 1'b1);
    @(negedge clk);
    n_checks++; if (overflow !== 1'b0) $display("FAIL overflow_clear: got %b expected 0", overflow); else n_pass++;
    wait_drain("overflow_next");
  endtask

  task automatic test_all_zero();
    int v0, d0, prev;
    v0 = n_valid_cyc;
    d0 = n_done;
    prev = 0;
    @(posedge clk); #1;
    for (int r = 0; r < ROWS; r++) begin
      send_row('0, 1'b0);
      if (r > 0) begin
        n_checks++;
        if (acc_cyc - prev !== 2)
          $display("FAIL all_zero_rate%0d: got %0d cycles between accepts expected 2", r, acc_cyc - prev);
        else n_pass++;
      end
      prev = acc_cyc;
    end
    wait_drain("all_zero");
    n_checks++; if (n_valid_cyc - v0 !== 0) $display("FAIL all_zero_valid: got %0d valid cycles expected 0", n_valid_cyc - v0); else n_pass++;
    n_checks++; if (n_done - d0 !== 1) $display("FAIL all_zero_done: got %0d pulses expected 1", n_done - d0); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [COLS*DATA_W-1:0] data;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) send_row('0, 1'b0);
    data = '0;
    data[4*8 +: 8] = 8'h55;
    data[6*8 +: 8] = 8'h66;
    out_ready = 1'b0;
    send_row(data, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_row, out_col, out_data} !== {1'b1, 3'd3, 3'd4, 8'h55})
      $display("FAIL pre_reset_entry: got v=%b row=%0d col=%0d data=%02h, expected v=1 row=3 col=4 data=55",
               out_valid, out_row, out_col, out_data);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL async_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL async_in_ready: got %b expected 1", in_ready); else n_pass++;
    exp_q.delete();
    done_q.delete();
    m_row = 0;
    m_nnz = 0;
    m_ovf = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b1;
    data = '0;
    data[0 +: 8] = 8'h77;
    send_row(data, 1'b1);
    @(negedge clk);
    n_checks++; if (out_row !== 3'd0) $display("FAIL post_reset_row: got %0d expected 0", out_row); else n_pass++;
    wait_drain("async_reset");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_zero_encoding();
    test_backpressure();
    test_overflow();
    test_all_zero();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at 500000, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sparse_coo_encoder.md
Name: sparse_coo_encoder

Overview:
- Dense-to-COO compressor: takes an FP8 matrix one row per handshake and emits one (row, col, data) COO entry per nonzero element over a valid/ready stream.
- Produces the A/B entry lists consumed by the sparse COO matmul: data in FP8, row/col indices, and a per-matrix entry count.
- Caps emitted entries at the downstream list capacity and flags any overflow.

Parameters:
- DATA_W, 8, element width (FP8: sign[7], exponent[6:3], mantissa[2:0]).
- ROWS, 8, rows per matrix.
- COLS, 8, elements per input row.
- MAX_NNZ, 8, maximum entries emitted per matrix (downstream list depth).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input row valid.
- in_ready  out  1  encoder can accept a row.
- in_data  in  COLS*DATA_W  dense row; element c is in_data[c*DATA_W +: DATA_W].
- in_last  in  1  this row is the final row of the matrix.
- out_valid  out  1  COO entry valid.
- out_ready  in  1  downstream accepts entry.
- out_data  out  DATA_W  element value, bit-exact copy of input.
- out_row  out  $clog2(ROWS)  row index.
- out_col  out  $clog2(COLS)  column index.
- done  out  1  one-cycle pulse: matrix fully encoded.
- nnz_count  out  $clog2(MAX_NNZ+1)  entries emitted for the matrix; valid while done=1.
- overflow  out  1  sticky: nonzeros dropped in the current or last matrix.

Behaviour:
- Zero test: element is zero iff exponent==0 and mantissa==0; sign is ignored, so 0x80 is zero. Every other code, including 0x01, is nonzero.
- Reset (rst=0, async): state IDLE. in_ready=1, out_valid=0, done=0, nnz_count=0, overflow=0, row counter=0, held row and mask cleared. Reset mid-row discards the held row with no further output.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data and in_last, build the nonzero mask, go to SCAN.
  - If the row counter is 0 (first row of a matrix), clear nnz_count and overflow on that edge.
- SCAN:
  - in_ready=0.
  - out_valid=1 while the mask is nonzero and nnz<MAX_NNZ.
  - Presents the lowest-index set mask bit: out_col = that index, out_row = row counter, out_data = held element.
  - On out_valid&&out_ready: clear that mask bit and increment nnz.
  - out_* must stay stable while out_valid=1 and out_ready=0.
  - If nnz==MAX_NNZ and the mask is nonzero: set overflow, clear the mask, out_valid stays 0 (drop, no emission).
- SCAN exit (mask empty: all-zero row, last entry accepted, or overflow drop):
  - Exit takes effect on the next edge. An all-zero row costs exactly one SCAN cycle with out_valid=0.
  - If held last=1 or row counter==ROWS-1: go to DONE and reset the row counter to 0.
  - Otherwise: increment the row counter and go to IDLE.
- DONE: done=1 for exactly one cycle, nnz_count holds the final count; then IDLE. in_ready=0 in DONE.
- Throughput: a row with k emitted entries, no backpressure, occupies 1 (IDLE accept) + max(k,1) SCAN cycles.
- nnz_count saturates at MAX_NNZ. overflow stays set until the first row of the next matrix is accepted.
- Row counter wraps to 0 after ROWS rows even if in_last is never seen; the ROWS-th row ends the matrix.
- in_valid is ignored outside IDLE; upstream must hold in_valid/in_data until in_ready.

Test Plan:
- Identity: row r has 0x38 at column r, others 0x00, in_last on row 7, out_ready=1 → 8 entries (r,r,0x38) in row order; done pulse with nnz_count=8, overflow=0.
- Zero encoding: row 0 = {0x80,0x01,0x00,0x00,0x00,0x00,0x00,0xB8}, in_last=1 → exactly two entries, (0,1,0x01) then (0,7,0xB8); nnz_count=2.
- Backpressure: row with nonzeros at cols 2,5; out_ready low for 3 cycles at the first entry → (0,2) held stable through the stall, then (0,5); no loss or duplication.
- Overflow: 2 rows of 8×0x40, in_last on row 1 → 8 entries, all row 0; row 1 dropped; done with nnz_count=8, overflow=1; the next matrix's first accepted row clears overflow.
- All-zero matrix: 8 rows of 0x00 → no out_valid ever; done once after row 7 with nnz_count=0; each row accepted every 2 cycles.
- Async reset mid-SCAN: assert rst=0 while entry (3,4) is presented → out_valid drops immediately; after release in_ready=1 and the next row is numbered row 0.
